gray_to_rgb565_expander: RTL and testbench
==========================================

Name: gray_to_rgb565_expander

Overview:
- Streaming expander that turns packed 8-bit grayscale pixels back into RGB565 for the framebuffer/display path. It is the inverse direction of the RGB565-to-grayscale conversion stage.
- Accepts 32-bit words of four grayscale pixels over a valid/ready input and emits 32-bit words of two RGB565 pixels over a valid/ready output.
- Sits between the grayscale processing buffer and the DMA/framebuffer writer.

Parameters:
- MSB_FIRST, 1, 1: pixel 0 occupies the most significant byte/halfword (big-endian bus); 0: pixel 0 occupies the least significant byte/halfword.
- COUNT_WIDTH, 16, width of the emitted-pixel counter.

Ports:
- clock  in  1  system clock, all state on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: drops all held data and zeroes the counter.
- sWord  in  32  four grayscale pixels.
- sLast  in  1  marks the final input word of a frame.
- sValid  in  1  input word valid.
- sReady  out  1  expander can accept sWord this cycle.
- mWord  out  32  two RGB565 pixels.
- mLast  out  1  set on the second output word derived from an sLast input.
- mValid  out  1  output word valid.
- mReady  in  1  downstream accepts mWord.
- pixelCount  out  COUNT_WIDTH  RGB565 pixels emitted since reset/clear/frame end.

Behaviour:
- Reset (nReset low, asynchronous): state EMPTY, mValid=0, mWord=0, mLast=0, pixelCount=0, hold register=0. sReady follows from state EMPTY, so it reads 1 while the block is in reset.
- Pixel map: gray g[7:0] -> {g[7:3], g[7:2], g[7:3]}, i.e. R5=g>>3, G6=g>>2, B5=g>>3. Pure truncation, no rounding. Example: 0xFF->0xFFFF, 0x80->0x8410, 0x00->0x0000.
- Pixel order with MSB_FIRST=1:
  - input pixel k sits in sWord[31-8k -: 8];
  - output word 0 = {p0,p1}, output word 1 = {p2,p3}, with p0/p2 in mWord[31:16].
- Pixel order with MSB_FIRST=0: mirror image; pixel 0 sits in the low byte/halfword.
- Input handshake: transfer when sValid&&sReady at a rising edge. The word and sLast are captured into the hold register.
- Output handshake:
  - transfer when mValid&&mReady;
  - mWord/mLast hold stable while mValid&&!mReady.
- Output advance: advance = !mValid || mReady. The output register loads only when advance=1.
- State machine:
  - EMPTY: nothing held. sReady=1. An input transfer -> HALF0.
  - HALF0: upper pair pending. If advance: load output with pair 0, mLast=0, mValid=1 -> HALF1. sReady=0.
  - HALF1: lower pair pending. If advance: load pair 1 with mLast=held sLast, mValid=1. Input transfer in the same cycle -> HALF0, otherwise -> EMPTY. sReady=advance (combinational on mReady).
  - EMPTY with advance: mValid<=0 (a drained output clears).
- Throughput: one output word per cycle and one input word per two cycles under continuous valid/ready, with no bubbles.
- Latency: word accepted at edge k -> first output word valid after edge k+1; second output word after edge k+2 if mReady=1.
- pixelCount:
  - +2 on each output transfer;
  - reset to 0 on the cycle after the output transfer carrying mLast=1;
  - wraps modulo 2^COUNT_WIDTH.
- clear:
  - state->EMPTY, mValid=0, mLast=0, pixelCount=0;
  - overrides any simultaneous transfer;
  - sReady is still driven per state, but any input accepted in that cycle is discarded.
- nReset asserted mid-word: the partial word is lost and no output is produced for it.

Test Plan:
- Single word, MSB_FIRST=1, sWord=0xFF80_4000, mReady=1 -> mWord 0xFFFF_8410 one cycle after acceptance, then 0x4208_0000; pixelCount 2 then 4; sReady low during HALF0.
- Back-to-back stream of 8 words, sValid/mReady held 1 -> 16 consecutive output words with no mValid gap; sReady toggles 1,0; pixelCount=32.
- Backpressure: mReady=0 for 5 cycles while mValid=1 -> mWord/mLast stable, sReady=0, no input lost; release -> correct order resumes.
- sLast on third word of a frame -> mLast=1 only on the 6th output word; pixelCount=12 at that transfer, then 0.
- MSB_FIRST=0, sWord=0x0000_80FF -> first output 0x8410_FFFF, second 0x0000_0000.
- clear asserted in HALF1 with mValid=1, and nReset pulsed mid-stream -> mValid=0, pixelCount=0, state EMPTY (sReady=1) next cycle / immediately on reset.

Source files
------------

// File: rtl/gray_to_rgb565_expander_if.sv
// Stream bundle between the grayscale buffer, the expander and the framebuffer writer.
// slave: the expander's view (consumes s*, produces m*); master: the surrounding environment.
interface gray_to_rgb565_expander_if;
  localparam int unsigned WORD_W = 32;

  logic [WORD_W-1:0] sWord;
  logic              sLast;
  logic              sValid;
  logic              sReady;
  logic [WORD_W-1:0] mWord;
  logic              mLast;
  logic              mValid;
  logic              mReady;

  modport slave (
    input  sWord, sLast, sValid, mReady,
    output sReady, mWord, mLast, mValid
  );

  modport master (
    output sWord, sLast, sValid, mReady,
    input  sReady, mWord, mLast, mValid
  );
endinterface

// File: rtl/gray_to_rgb565_expander.sv
// Expands words of four 8-bit gray pixels into two words of two RGB565 pixels each.
// One input word yields two output words; the hold register keeps the input word
// until its second pair has been loaded into the output register.
module gray_to_rgb565_expander #(
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   nReset,
  input  logic                   clear,
  gray_to_rgb565_expander_if.slave bus,
  output logic [COUNT_WIDTH-1:0] pixelCount
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned GRAY_W = 8;
  localparam int unsigned PIX_N  = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF0 = 2'd1,
    HALF1 = 2'd2
  } state_e;

  state_e                 state_q;
  logic [WORD_W-1:0]      hold_q;
  logic                   hold_last_q;
  logic [WORD_W-1:0]      mword_q;
  logic                   mlast_q;
  logic                   mvalid_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   wrap_q;

  logic                   advance_c;
  logic                   sready_c;
  logic                   in_xfer_c;
  logic                   out_xfer_c;
  logic [GRAY_W-1:0]      px_c [PIX_N];
  logic [WORD_W-1:0]      pair0_c;
  logic [WORD_W-1:0]      pair1_c;

  // Gray to RGB565 by truncation: R5 and B5 take the top five bits, G6 the top six.
  function automatic logic [15:0] gray_to_565(input logic [GRAY_W-1:0] g);
    return {g[7:3], g[7:2], g[7:3]};
  endfunction

  // Handshake qualifiers; sReady in HALF1 depends combinationally on mReady.
  always_comb begin
    advance_c  = !mvalid_q || bus.mReady;
    sready_c   = (state_q == EMPTY) || ((state_q == HALF1) && advance_c);
    in_xfer_c  = bus.sValid && sready_c;
    out_xfer_c = mvalid_q && bus.mReady;
  end

  // Unpack the held word into pixels 0..3 according to bus endianness.
  always_comb begin
    for (int k = 0; k < int'(PIX_N); k++) begin
      if (MSB_FIRST) begin
        px_c[k] = hold_q[(WORD_W-1) - GRAY_W*k -: GRAY_W];
      end else begin
        px_c[k] = hold_q[GRAY_W*k +: GRAY_W];
      end
    end
  end

  // Build both output pairs; the lower-numbered pixel goes to the high half on a big-endian bus.
  always_comb begin
    if (MSB_FIRST) begin
      pair0_c = {gray_to_565(px_c[0]), gray_to_565(px_c[1])};
      pair1_c = {gray_to_565(px_c[2]), gray_to_565(px_c[3])};
    end else begin
      pair0_c = {gray_to_565(px_c[1]), gray_to_565(px_c[0])};
      pair1_c = {gray_to_565(px_c[3]), gray_to_565(px_c[2])};
    end
  end

  // Pixel counter next value: restart one cycle after the frame's last transfer, +2 per transfer.
  always_comb begin
    count_d = wrap_q ? '0 : count_q;
    if (out_xfer_c) begin
      count_d = count_d + COUNT_WIDTH'(2);
    end
  end

  // Pixel counter and its frame-end restart flag.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= out_xfer_c && mlast_q;
    end
  end

  // Control FSM with registered output word, last flag and valid.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= EMPTY;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      mword_q     <= '0;
      mlast_q     <= 1'b0;
      mvalid_q    <= 1'b0;
    end else if (clear) begin
      state_q     <= EMPTY;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      mlast_q     <= 1'b0;
      mvalid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (advance_c) begin
            mvalid_q <= 1'b0;
            mlast_q  <= 1'b0;
          end
          if (in_xfer_c) begin
            hold_q      <= bus.sWord;
            hold_last_q <= bus.sLast;
            state_q     <= HALF0;
          end
        end
        HALF0: begin
          if (advance_c) begin
            mword_q  <= pair0_c;
            mlast_q  <= 1'b0;
            mvalid_q <= 1'b1;
            state_q  <= HALF1;
          end
        end
        HALF1: begin
          if (advance_c) begin
            mword_q  <= pair1_c;
            mlast_q  <= hold_last_q;
            mvalid_q <= 1'b1;
            if (in_xfer_c) begin
              hold_q      <= bus.sWord;
              hold_last_q <= bus.sLast;
              state_q     <= HALF0;
            end else begin
              state_q <= EMPTY;
            end
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

  assign bus.sReady = sready_c;
  assign bus.mWord  = mword_q;
  assign bus.mLast  = mlast_q;
  assign bus.mValid = mvalid_q;
  assign pixelCount = count_q;

endmodule

// File: tb/tb_gray_to_rgb565_expander.sv
// Bench for the gray-to-RGB565 expander: one big-endian and one little-endian instance
// share the same stimulus and are each checked against a pixel-level reference model.
module tb_gray_to_rgb565_expander;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        clr = 1'b0;
  logic        sv = 1'b0;
  logic        sl = 1'b0;
  logic        mr = 1'b1;
  logic [31:0] sw = '0;
  logic [15:0] pc0;
  logic [15:0] pc1;

  int n_cmp = 0;
  int n_err = 0;
  int xfer_cnt = 0;

  // Reference model per instance (index 0: little-endian, 1: big-endian)
  int          pend [2];      // output pairs received but not yet presented
  logic [31:0] pw   [2][2];   // those pairs, oldest first
  logic        pl   [2][2];
  logic        full [2];      // an output word is being presented
  logic [31:0] ow   [2];
  logic        ol   [2];
  int          cnt  [2];
  logic        fe   [2];      // previous cycle carried the frame's last transfer

  always #5 clock = ~clock;

  gray_to_rgb565_expander_if u_if0 ();
  gray_to_rgb565_expander_if u_if1 ();

  assign u_if0.sWord  = sw;
  assign u_if0.sLast  = sl;
  assign u_if0.sValid = sv;
  assign u_if0.mReady = mr;
  assign u_if1.sWord  = sw;
  assign u_if1.sLast  = sl;
  assign u_if1.sValid = sv;
  assign u_if1.mReady = mr;

  gray_to_rgb565_expander #(.MSB_FIRST(1'b0), .COUNT_WIDTH(16)) u_dut0 (
    .clock(clock), .nReset(nReset), .clear(clr), .bus(u_if0), .pixelCount(pc0)
  );

  gray_to_rgb565_expander #(.MSB_FIRST(1'b1), .COUNT_WIDTH(16)) u_dut1 (
    .clock(clock), .nReset(nReset), .clear(clr), .bus(u_if1), .pixelCount(pc1)
  );

  function automatic logic [15:0] rgb(input int g);
    return 16'(((g / 8) * 2048) + ((g / 4) * 32) + (g / 8));
  endfunction

  function automatic int pix(input bit msb, input logic [31:0] w, input int k);
    int sh;
    sh = msb ? (24 - 8 * k) : (8 * k);
    return int'((w >> sh) & 32'hFF);
  endfunction

  // Output word h (0 or 1) of an input word for instance d.
  function automatic logic [31:0] pair_word(input int d, input logic [31:0] w, input int h);
    bit msb;
    int pa, pb;
    msb = (d == 1);
    pa  = pix(msb, w, 2 * h);
    pb  = pix(msb, w, 2 * h + 1);
    return msb ? {rgb(pa), rgb(pb)} : {rgb(pb), rgb(pa)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int d, output logic sr, output logic mv, output logic ml,
                         output logic [31:0] mw, output logic [15:0] pc);
    if (d == 1) begin
      sr = u_if1.sReady; mv = u_if1.mValid; ml = u_if1.mLast; mw = u_if1.mWord; pc = pc1;
    end else begin
      sr = u_if0.sReady; mv = u_if0.mValid; ml = u_if0.mLast; mw = u_if0.mWord; pc = pc0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pend[d] = 0; full[d] = 1'b0; ow[d] = '0; ol[d] = 1'b0; cnt[d] = 0; fe[d] = 1'b0;
    end
  endtask

  function automatic logic exp_sready(input int d);
    return (pend[d] == 0) || ((pend[d] == 1) && (!full[d] || mr));
  endfunction

  task automatic check_dut(input int d);
    logic sr, mv, ml;
    logic [31:0] mw;
    logic [15:0] pc;
    get_obs(d, sr, mv, ml, mw, pc);
    chk($sformatf("d%0d sReady", d), 32'(sr), 32'(exp_sready(d)));
    chk($sformatf("d%0d mValid", d), 32'(mv), 32'(full[d]));
    if (full[d]) begin
      chk($sformatf("d%0d mWord", d), mw, ow[d]);
      chk($sformatf("d%0d mLast", d), 32'(ml), 32'(ol[d]));
    end
    chk($sformatf("d%0d pixelCount", d), 32'(pc), 32'(cnt[d]));
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge(input int d);
    logic sready, adv, xo;
    int base;
    sready = exp_sready(d);
    if (clr) begin
      pend[d] = 0; full[d] = 1'b0; ol[d] = 1'b0; cnt[d] = 0; fe[d] = 1'b0;
      return;
    end
    adv  = !full[d] || mr;
    xo   = full[d] && mr;
    base = fe[d] ? 0 : cnt[d];
    if (xo) base = base + 2;
    cnt[d] = base % 65536;
    fe[d]  = xo && ol[d];
    if (adv) begin
      if (pend[d] > 0) begin
        ow[d] = pw[d][0]; ol[d] = pl[d][0];
        pw[d][0] = pw[d][1]; pl[d][0] = pl[d][1];
        pend[d] = pend[d] - 1;
        full[d] = 1'b1;
      end else begin
        full[d] = 1'b0;
      end
    end
    if (sv && sready) begin
      pw[d][pend[d]]     = pair_word(d, sw, 0);
      pl[d][pend[d]]     = 1'b0;
      pw[d][pend[d] + 1] = pair_word(d, sw, 1);
      pl[d][pend[d] + 1] = sl;
      pend[d] = pend[d] + 2;
    end
  endtask

  // One clock: check both instances away from the edge, update the model, cross the edge.
  task automatic step();
    @(negedge clock);
    for (int d = 0; d < 2; d++) check_dut(d);
    if (u_if1.mValid && mr) xfer_cnt++;
    for (int d = 0; d < 2; d++) model_edge(d);
    @(posedge clock);
    #1;
  endtask

  // Offer one word until the big-endian instance accepts it (bounded).
  task automatic send(input logic [31:0] w, input logic last);
    logic took, t;
    sv = 1'b1; sw = w; sl = last; took = 1'b0;
    for (int c = 0; c < 50 && !took; c++) begin
      t = u_if1.sReady;
      step();
      took = t;
    end
    sv = 1'b0; sl = 1'b0;
    chk("send accepted", 32'(took), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    model_reset();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst sReady", 32'(u_if1.sReady), 32'd1);
    chk("rst mValid", 32'(u_if1.mValid), 32'd0);
    chk("rst mWord", u_if1.mWord, 32'd0);
    chk("rst mLast", 32'(u_if1.mLast), 32'd0);
    chk("rst pixelCount", 32'(pc1), 32'd0);
    chk("rst d0 mValid", 32'(u_if0.mValid), 32'd0);
    nReset = 1'b1;
    step();

    // Single word, big-endian directed values
    send(32'hFF80_4000, 1'b0);
    chk("half0 sReady", 32'(u_if1.sReady), 32'd0);
    step();
    chk("w0 d1 mWord", u_if1.mWord, 32'hFFFF_8410);
    chk("w0 d0 mWord", u_if0.mWord, 32'h4208_0000);
    step();
    chk("w1 d1 mWord", u_if1.mWord, 32'h4208_0000);
    chk("w1 d0 mWord", u_if0.mWord, 32'hFFFF_8410);
    chk("w1 pixelCount", 32'(pc1), 32'd2);
    step();
    chk("single pixelCount", 32'(pc1), 32'd4);
    chk("single drained", 32'(u_if1.mValid), 32'd0);

    // Little-endian directed values
    send(32'h0000_80FF, 1'b0);
    step();
    chk("le w0 mWord", u_if0.mWord, 32'h8410_FFFF);
    step();
    chk("le w1 mWord", u_if0.mWord, 32'h0000_0000);
    repeat (2) step();

    // Flush, then back-to-back stream of eight words
    clr = 1'b1; step(); clr = 1'b0;
    chk("clear pixelCount", 32'(pc1), 32'd0);
    mr = 1'b1;
    for (int i = 0; i < 8; i++) send($urandom, 1'b0);
    repeat (4) step();
    chk("stream pixelCount d1", 32'(pc1), 32'd32);
    chk("stream pixelCount d0", 32'(pc0), 32'd32);

    // Backpressure for five cycles with a word presented
    a = $urandom;
    send(a, 1'b0);
    mr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp sReady", 32'(u_if1.sReady), 32'd0);
      chk("bp mWord", u_if1.mWord, pair_word(1, a, 0));
    end
    mr = 1'b1;
    send($urandom, 1'b0);
    repeat (5) step();

    // Frame of three words; sLast on the third
    clr = 1'b1; step(); clr = 1'b0;
    xfer_cnt = 0;
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    send($urandom, 1'b1);
    for (int c = 0; c < 20 && xfer_cnt < 5; c++) step();
    chk("frame 6th mValid", 32'(u_if1.mValid), 32'd1);
    chk("frame 6th mLast", 32'(u_if1.mLast), 32'd1);
    step();
    chk("frame end pixelCount", 32'(pc1), 32'd12);
    step();
    chk("frame restart pixelCount", 32'(pc1), 32'd0);

    // Randomised traffic with occasional frame ends and flushes
    for (int i = 0; i < 400; i++) begin
      sv  = ($urandom_range(3) != 0);
      mr  = ($urandom_range(3) != 0);
      sw  = $urandom;
      sl  = ($urandom_range(4) == 0);
      clr = ($urandom_range(49) == 0);
      step();
    end
    sv = 1'b0; sl = 1'b0; clr = 1'b0; mr = 1'b1;
    repeat (4) step();

    // Flush while the second pair is pending and a word is presented
    send($urandom, 1'b0);
    step();
    chk("pre-clear mValid", 32'(u_if1.mValid), 32'd1);
    mr = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; mr = 1'b1;
    chk("post-clear mValid", 32'(u_if1.mValid), 32'd0);
    chk("post-clear sReady", 32'(u_if1.sReady), 32'd1);
    chk("post-clear pixelCount", 32'(pc1), 32'd0);
    repeat (2) step();

    // Asynchronous reset in the middle of a word
    send($urandom, 1'b0);
    step();
    nReset = 1'b0;
    #1;
    model_reset();
    chk("async rst mValid", 32'(u_if1.mValid), 32'd0);
    chk("async rst sReady", 32'(u_if1.sReady), 32'd1);
    chk("async rst pixelCount", 32'(pc1), 32'd0);
    chk("async rst mWord", u_if1.mWord, 32'd0);
    @(posedge clock);
    #1;
    nReset = 1'b1;
    repeat (4) step();
    chk("after rst idle", 32'(u_if1.mValid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
